// File: rtl/snake_pkg.sv
// Shared constants and enumerations for the snake game's plot scheduler.
package snake_pkg;

   localparam int SCREEN_W  = 160;
   localparam int SCREEN_H  = 120;
   localparam int CELL_SIZE = 4;

   localparam logic [2:0] BG_COLOUR   = 3'b000;
   localparam logic [2:0] FOOD_COLOUR = 3'b100;

   typedef enum logic [1:0] {IDLE, CELL, FULL, DONE} state_t;

   typedef enum logic [1:0] {CLR, ERASE, HEAD, FOOD} client_t;

endpackage

// File: rtl/plot_raster_counter.sv
// Pixel position generator: a 4x4 cell walk (cell mode) or a full-screen
// raster scan (full mode). Exposes the position the counter will hold after
// the coming edge so the scheduler can register its pixel outputs in step.
import snake_pkg::*;

module plot_raster_counter (
   input  logic       clk,
   input  logic       resetn,
   input  logic       start,
   input  logic       step,
   input  logic       full_mode,
   output logic [7:0] nxt_px,
   output logic [6:0] nxt_py,
   output logic       last
);

   logic [7:0] px;
   logic [6:0] py;
   logic [7:0] x_lim;
   logic [6:0] y_lim;

   assign x_lim = full_mode ? 8'(SCREEN_W - 1) : 8'(CELL_SIZE - 1);
   assign y_lim = full_mode ? 7'(SCREEN_H - 1) : 7'(CELL_SIZE - 1);
   assign last  = (px == x_lim) && (py == y_lim);

   // Next position: x is the inner loop, y the outer loop.
   always_comb begin
      nxt_px = px;
      nxt_py = py;
      if (start) begin
         nxt_px = '0;
         nxt_py = '0;
      end else if (step) begin
         if (px == x_lim) begin
            nxt_px = '0;
            nxt_py = (py == y_lim) ? '0 : py + 7'd1;
         end else begin
            nxt_px = px + 8'd1;
         end
      end
   end

   // Position register.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         px <= '0;
         py <= '0;
      end else begin
         px <= nxt_px;
         py <= nxt_py;
      end
   end

endmodule

// File: rtl/plot_scheduler.sv
// Arbitrates the VGA adapter's single pixel-write port between the clear,
// tail-erase, head-draw and food-draw clients (fixed priority in that order)
// and expands each grant into sequential single-pixel plots.
// Build option PLOT_SCHED_CLIP_EN: when defined, cell pixels that fall off
// the visible screen are not plotted (timing unchanged); otherwise cell
// coordinates wrap modulo 256/128 and every pixel is plotted.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no operation; sample requests and grant the highest priority
// CELL  | plotting the 16 pixels of a 4x4 cell
// FULL  | plotting every screen pixel in BG_COLOUR (clear)
// DONE  | plot low; one-cycle done pulse to the granted client
import snake_pkg::*;

module plot_scheduler (
   input  logic       clk,
   input  logic       resetn,
   input  logic       clear_req,
   input  logic       erase_req,
   input  logic [7:0] erase_x,
   input  logic [6:0] erase_y,
   input  logic       head_req,
   input  logic [7:0] head_x,
   input  logic [6:0] head_y,
   input  logic [2:0] head_colour,
   input  logic       food_req,
   input  logic [7:0] food_x,
   input  logic [6:0] food_y,
   output logic       clear_done,
   output logic       erase_done,
   output logic       head_done,
   output logic       food_done,
   output logic [7:0] x,
   output logic [6:0] y,
   output logic [2:0] colour,
   output logic       plot,
   output logic       busy
);

   state_t     state;
   client_t    client;
   logic [7:0] bx;
   logic [6:0] by;
   logic [2:0] bcol;

   logic       grant;
   client_t    win;
   logic [7:0] win_x;
   logic [6:0] win_y;
   logic [2:0] win_col;

   logic [7:0] nxt_px;
   logic [6:0] nxt_py;
   logic       cnt_last;
   logic       cnt_start;
   logic       cnt_step;

   logic [7:0] base_x;
   logic [6:0] base_y;
   logic [7:0] pix_x;
   logic [6:0] pix_y;
   logic       pix_on;

   assign busy      = (state != IDLE);
   assign cnt_start = (state == IDLE);
   assign cnt_step  = ((state == CELL) || (state == FULL)) && !cnt_last;

   plot_raster_counter u_raster (
      .clk       (clk),
      .resetn    (resetn),
      .start     (cnt_start),
      .step      (cnt_step),
      .full_mode (state == FULL),
      .nxt_px    (nxt_px),
      .nxt_py    (nxt_py),
      .last      (cnt_last)
   );

   // Fixed-priority winner selection; a clear is a scan based at the origin.
   always_comb begin
      grant   = clear_req | erase_req | head_req | food_req;
      win     = FOOD;
      win_x   = food_x;
      win_y   = food_y;
      win_col = FOOD_COLOUR;
      if (clear_req) begin
         win     = CLR;
         win_x   = '0;
         win_y   = '0;
         win_col = BG_COLOUR;
      end else if (erase_req) begin
         win     = ERASE;
         win_x   = erase_x;
         win_y   = erase_y;
         win_col = BG_COLOUR;
      end else if (head_req) begin
         win     = HEAD;
         win_x   = head_x;
         win_y   = head_y;
         win_col = head_colour;
      end
   end

   // The grant edge already emits pixel 0, so it uses the live winner inputs;
   // later pixels use the coordinates latched at grant.
   assign base_x = (state == IDLE) ? win_x : bx;
   assign base_y = (state == IDLE) ? win_y : by;
   assign pix_x  = base_x + nxt_px;
   assign pix_y  = base_y + nxt_py;

`ifdef PLOT_SCHED_CLIP_EN
   logic [8:0] sum_x;
   logic [7:0] sum_y;
   logic       in_full;

   assign sum_x   = {1'b0, base_x} + {1'b0, nxt_px};
   assign sum_y   = {1'b0, base_y} + {1'b0, nxt_py};
   assign in_full = (state == IDLE) ? (win == CLR) : (state == FULL);
   assign pix_on  = in_full || ((sum_x < 9'(SCREEN_W)) && (sum_y < 8'(SCREEN_H)));
`else
   assign pix_on  = 1'b1;
`endif

   // Scheduler FSM with registered adapter outputs and done pulses.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state      <= IDLE;
         client     <= CLR;
         bx         <= '0;
         by         <= '0;
         bcol       <= '0;
         x          <= '0;
         y          <= '0;
         colour     <= '0;
         plot       <= 1'b0;
         clear_done <= 1'b0;
         erase_done <= 1'b0;
         head_done  <= 1'b0;
         food_done  <= 1'b0;
      end else begin
         clear_done <= 1'b0;
         erase_done <= 1'b0;
         head_done  <= 1'b0;
         food_done  <= 1'b0;
         case (state)
            IDLE: begin
               plot <= 1'b0;
               if (grant) begin
                  client <= win;
                  bx     <= win_x;
                  by     <= win_y;
                  bcol   <= win_col;
                  x      <= pix_x;
                  y      <= pix_y;
                  colour <= win_col;
                  plot   <= pix_on;
                  state  <= (win == CLR) ? FULL : CELL;
               end
            end
            CELL, FULL: begin
               if (cnt_last) begin
                  plot  <= 1'b0;
                  state <= DONE;
                  case (client)
                     CLR:   clear_done <= 1'b1;
                     ERASE: erase_done <= 1'b1;
                     HEAD:  head_done  <= 1'b1;
                     FOOD:  food_done  <= 1'b1;
                  endcase
               end else begin
                  x      <= pix_x;
                  y      <= pix_y;
                  colour <= bcol;
                  plot   <= pix_on;
               end
            end
            DONE: begin
               plot  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_plot_scheduler.sv
// Self-checking bench for plot_scheduler: directed timing steps plus
// randomized request mixes compared against a pixel-list reference model.
module tb_plot_scheduler;

   logic       clk = 1'b0;
   logic       resetn = 1'b0;
   logic       clear_req = 1'b0, erase_req = 1'b0, head_req = 1'b0, food_req = 1'b0;
   logic [7:0] erase_x = '0, head_x = '0, food_x = '0;
   logic [6:0] erase_y = '0, head_y = '0, food_y = '0;
   logic [2:0] head_colour = '0;
   logic       clear_done, erase_done, head_done, food_done;
   logic [7:0] x;
   logic [6:0] y;
   logic [2:0] colour;
   logic       plot, busy;

   int checks = 0;
   int errors = 0;

   logic [17:0] plot_q[$];
   logic [17:0] exp_q[$];
   int          done_q[$];
   int          exp_done[$];

   always #5 clk = ~clk;

   plot_scheduler dut (
      .clk(clk), .resetn(resetn),
      .clear_req(clear_req),
      .erase_req(erase_req), .erase_x(erase_x), .erase_y(erase_y),
      .head_req(head_req), .head_x(head_x), .head_y(head_y), .head_colour(head_colour),
      .food_req(food_req), .food_x(food_x), .food_y(food_y),
      .clear_done(clear_done), .erase_done(erase_done),
      .head_done(head_done), .food_done(food_done),
      .x(x), .y(y), .colour(colour), .plot(plot), .busy(busy)
   );

   // Record every plotted pixel and every done pulse.
   always @(negedge clk) begin
      if (resetn) begin
         if (plot)       plot_q.push_back({x, y, colour});
         if (clear_done) done_q.push_back(0);
         if (erase_done) done_q.push_back(1);
         if (head_done)  done_q.push_back(2);
         if (food_done)  done_q.push_back(3);
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Model: a cell is 16 pixels, row by row, each offset added with wrap.
   function automatic void add_cell(input int bx, input int by, input logic [2:0] col);
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            int xs;
            int ys;
            bit on;
            logic [7:0] xw;
            logic [6:0] yw;
            xs = bx + c;
            ys = by + r;
            on = 1'b1;
`ifdef PLOT_SCHED_CLIP_EN
            on = (xs < 160) && (ys < 120);
`endif
            xw = 8'(xs % 256);
            yw = 7'(ys % 128);
            if (on) exp_q.push_back({xw, yw, col});
         end
      end
   endfunction

   function automatic void add_clear();
      for (int r = 0; r < 120; r++)
         for (int c = 0; c < 160; c++)
            exp_q.push_back({8'(c), 7'(r), 3'b000});
   endfunction

   // Hold requests until each sees its done; optionally withdraw food early.
   task automatic run_reqs(input bit c, input bit e, input bit h, input bit f,
                           input int drop_f_at, output int first_done);
      int n;
      n = 0;
      first_done = -1;
      clear_req = c; erase_req = e; head_req = h; food_req = f;
      while ((clear_req | erase_req | head_req | food_req) && n < 25000) begin
         @(negedge clk);
         n++;
         if (first_done < 0 && (clear_done | erase_done | head_done | food_done))
            first_done = n;
         if (clear_done) clear_req = 1'b0;
         if (erase_done) erase_req = 1'b0;
         if (head_done)  head_req  = 1'b0;
         if (food_done)  food_req  = 1'b0;
         if (n == drop_f_at) food_req = 1'b0;
      end
      check("run_timeout", 32'(n < 25000), 32'd1);
      clear_req = 1'b0; erase_req = 1'b0; head_req = 1'b0; food_req = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic compare_run(input string tag);
      int mism;
      int n;
      mism = 0;
      check({tag, "_plot_count"}, 32'(plot_q.size()), 32'(exp_q.size()));
      n = (plot_q.size() < exp_q.size()) ? plot_q.size() : exp_q.size();
      for (int i = 0; i < n; i++)
         if (plot_q[i] !== exp_q[i]) mism++;
      check({tag, "_pixel_mismatches"}, 32'(mism), 32'd0);
      check({tag, "_done_count"}, 32'(done_q.size()), 32'(exp_done.size()));
      mism = 0;
      n = (done_q.size() < exp_done.size()) ? done_q.size() : exp_done.size();
      for (int i = 0; i < n; i++)
         if (done_q[i] != exp_done[i]) mism++;
      check({tag, "_done_order"}, 32'(mism), 32'd0);
      plot_q.delete(); exp_q.delete(); done_q.delete(); exp_done.delete();
   endtask

   initial begin
      int fd;
      logic [17:0] got;

      // Reset state.
      repeat (2) @(negedge clk);
      check("rst_xy_colour", {x, y, colour}, 32'd0);
      check("rst_plot_busy", {plot, busy}, 32'd0);
      check("rst_dones", {clear_done, erase_done, head_done, food_done}, 32'd0);
      resetn = 1'b1;
      @(negedge clk);

      // Cycle-accurate head draw; head_x moves mid-draw and must be ignored.
      head_x = 8'd80; head_y = 7'd60; head_colour = 3'b001;
      head_req = 1'b1;
      for (int n = 1; n <= 16; n++) begin
         @(negedge clk);
         got = {x, y, colour};
         check($sformatf("head_plot%0d", n), {plot, busy}, 32'b11);
         check($sformatf("head_pix%0d", n), got,
               {8'(80 + (n - 1) % 4), 7'(60 + (n - 1) / 4), 3'b001});
         if (n == 8) head_x = 8'd100;
      end
      @(negedge clk);
      check("head_done_c17", {plot, head_done, busy}, 32'b011);
      head_req = 1'b0;
      @(negedge clk);
      check("head_idle_c18", {head_done, busy}, 32'b00);
      repeat (2) @(negedge clk);
      check("head_total_plots", 32'(plot_q.size()), 32'd16);
      plot_q.delete(); done_q.delete();

      // Simultaneous erase and head: erase is served first.
      erase_x = 8'd76; erase_y = 7'd60; head_x = 8'd80; head_y = 7'd60; head_colour = 3'b001;
      add_cell(76, 60, 3'b000); add_cell(80, 60, 3'b001);
      exp_done.push_back(1); exp_done.push_back(2);
      run_reqs(0, 1, 1, 0, 0, fd);
      check("erase_head_latency", 32'(fd), 32'd17);
      compare_run("erase_head");

      // Full-screen clear.
      add_clear();
      exp_done.push_back(0);
      run_reqs(1, 0, 0, 0, 0, fd);
      check("clear_latency", 32'(fd), 32'd19201);
      if (plot_q.size() > 0) begin
         check("clear_first", plot_q[0], {8'd0, 7'd0, 3'b000});
         check("clear_last", plot_q[plot_q.size() - 1], {8'd159, 7'd119, 3'b000});
      end
      compare_run("clear");

      // Reset during the 5th plot of a food draw, then re-serve.
      food_x = 8'd40; food_y = 7'd20;
      food_req = 1'b1;
      repeat (5) @(negedge clk);
      check("food_pre_rst_plot", 32'(plot), 32'd1);
      resetn = 1'b0;
      #1;
      check("food_rst_plot_busy", {plot, busy}, 32'b00);
      repeat (2) begin
         @(negedge clk);
         check("food_rst_no_done", 32'(food_done), 32'd0);
      end
      check("food_rst_done_q", 32'(done_q.size()), 32'd0);
      plot_q.delete(); done_q.delete();
      resetn = 1'b1;
      add_cell(40, 20, 3'b100);
      exp_done.push_back(3);
      run_reqs(0, 0, 0, 1, 0, fd);
      check("food_reserve_latency", 32'(fd), 32'd17);
      compare_run("food_reserve");

      // Edge cell: wraps (or clips) but keeps 17-cycle timing.
      head_x = 8'd158; head_y = 7'd118; head_colour = 3'b101;
      add_cell(158, 118, 3'b101);
      exp_done.push_back(2);
      run_reqs(0, 0, 1, 0, 0, fd);
      check("edge_latency", 32'(fd), 32'd17);
      compare_run("edge_cell");

      // Randomized request mixes, including food withdrawn before its grant.
      for (int it = 0; it < 12; it++) begin
         bit e, h, f;
         int drop;
         e = 1'($urandom_range(0, 1));
         h = 1'($urandom_range(0, 1));
         f = 1'($urandom_range(0, 1));
         if (!(e | h | f)) h = 1'b1;
         drop = 0;
         if (f && (e | h) && $urandom_range(0, 2) == 0) drop = 3;
         erase_x = 8'($urandom_range(0, 255)); erase_y = 7'($urandom_range(0, 127));
         head_x  = 8'($urandom_range(0, 255)); head_y  = 7'($urandom_range(0, 127));
         food_x  = 8'($urandom_range(0, 255)); food_y  = 7'($urandom_range(0, 127));
         head_colour = 3'($urandom_range(0, 7));
         if (e) begin add_cell(int'(erase_x), int'(erase_y), 3'b000); exp_done.push_back(1); end
         if (h) begin add_cell(int'(head_x), int'(head_y), head_colour); exp_done.push_back(2); end
         if (f && drop == 0) begin add_cell(int'(food_x), int'(food_y), 3'b100); exp_done.push_back(3); end
         run_reqs(0, e, h, f, drop, fd);
         check($sformatf("rand%0d_latency", it), 32'(fd), 32'd17);
         compare_run($sformatf("rand%0d", it));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
